uart_tx_arbiter: RTL and testbench

Round-robin controller that shares the single UART `sender` between four byte requesters. It captures one byte from the winning requester and drives the sender's `tx_data`/`tx_en`. It then tracks the sender's idle/busy status through the frame and inserts a programmable inter-frame gap, counted in baud ticks. It sits between the application-side byte producers and `sender`, on the system clock, alongside the `watchmaker` baud divider.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART sender between four byte
// requesters. It captures the winning byte, drives tx_data/tx_en, follows the
// sender's idle/busy status through the frame, then waits GAP_TICKS baud edges
// before the next grant.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   send_clk        baud clock (square wave or one-cycle pulse), edge-detected
//   req[3:0]        level requests, held until acked
//   req_data[31:0]  requester i byte on [8i+7:8i]
//   ack[3:0]        one-hot, one-cycle capture pulse
//   tx_data[7:0]    byte to sender, stable from grant until back in IDLE
//   tx_en           send request to sender
//   tx_status       sender status, 1 = idle, 0 = transmitting
//   grant_id[1:0]   current/last granted requester
//   busy            high whenever not IDLE
//   err             sticky start-timeout flag
module uart_tx_arbiter #(
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send_clk,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_status,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_LIMIT = (GAP_TICKS > START_TIMEOUT) ? GAP_TICKS : START_TIMEOUT;
  localparam int unsigned CW        = (CNT_LIMIT < 1) ? 1 : $clog2(CNT_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP
  } state_t;

  state_t          state, state_d;
  logic            send_clk_q;
  logic            tick;
  logic [CW-1:0]   cnt, cnt_d, cnt_inc;
  logic [3:0]      ack_d;
  logic [7:0]      tx_data_d;
  logic            tx_en_d;
  logic [1:0]      grant_d;
  logic            err_d;
  logic            win_found;
  logic [1:0]      win_id;
  logic [1:0]      cand;
  logic [7:0]      win_byte;

  // One cycle of history turns either a square wave or a pulse into a tick.
  assign tick    = send_clk & ~send_clk_q;
  // Saturating increment so the counter never wraps.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  // Circular search for the first active request after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_id    = grant_id;
    cand      = '0;
    for (int k = 0; k < 4; k++) begin
      cand = grant_id + 2'(k + 1);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign win_byte = req_data[{win_id, 3'b000} +: 8];

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ack_d     = '0;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data;
    grant_d   = grant_id;
    err_d     = err;
    unique case (state)
      S_IDLE: begin
        // A sender still busy from before a reset blocks the grant.
        if (win_found && tx_status) begin
          state_d   = S_LOAD;
          ack_d     = 4'(4'b0001 << win_id);
          tx_data_d = win_byte;
          grant_d   = win_id;
          tx_en_d   = 1'b1;
          cnt_d     = '0;
        end
      end
      S_LOAD: begin
        tx_en_d = 1'b1;
        // Sender going busy wins over a coincident timeout tick.
        if (!tx_status) begin
          state_d = S_SEND;
          tx_en_d = 1'b0;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CW'(START_TIMEOUT)) begin
            state_d = S_GAP;
            tx_en_d = 1'b0;
            err_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_SEND: begin
        if (tx_status) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (GAP_TICKS == 0) begin
          state_d = S_IDLE;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CW'(GAP_TICKS)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      send_clk_q <= 1'b0;
      cnt        <= '0;
      ack        <= '0;
      tx_en      <= 1'b0;
      tx_data    <= '0;
      grant_id   <= 2'd3;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      send_clk_q <= send_clk;
      cnt        <= cnt_d;
      ack        <= ack_d;
      tx_en      <= tx_en_d;
      tx_data    <= tx_data_d;
      grant_id   <= grant_d;
      busy       <= (state_d != S_IDLE);
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a default instance (gap 2, timeout 4)
// and a zero-gap instance, each with its own behavioural sender model.
module tb_uart_tx_arbiter;

  localparam int GAP = 2;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        send_clk = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_status = 1'b1;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;

  logic [3:0]  req1 = '0;
  logic [31:0] req_data1 = '0;
  logic        tx_status1 = 1'b1;
  logic [3:0]  ack1;
  logic [7:0]  tx_data1;
  logic        tx_en1;
  logic [1:0]  grant_id1;
  logic        busy1;
  logic        err1;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(.GAP_TICKS(GAP), .START_TIMEOUT(TMO)) u0 (
    .clk(clk), .reset(reset), .send_clk(send_clk), .req(req), .req_data(req_data),
    .ack(ack), .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  uart_tx_arbiter #(.GAP_TICKS(0), .START_TIMEOUT(TMO)) u1 (
    .clk(clk), .reset(reset), .send_clk(send_clk), .req(req1), .req_data(req_data1),
    .ack(ack1), .tx_data(tx_data1), .tx_en(tx_en1), .tx_status(tx_status1),
    .grant_id(grant_id1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  // Baud source: changes just after a rising clk edge; tick_next says whether
  // the upcoming clk edge sees a send_clk rising edge.
  int   baud_period = 6;
  bit   baud_pulse = 1'b0;
  int   baud_cnt = 0;
  logic sc_prev = 1'b0;
  bit   tick_next = 1'b0;
  always begin
    @(posedge clk);
    #1;
    baud_cnt = (baud_cnt + 1 >= baud_period) ? 0 : baud_cnt + 1;
    sc_prev  = send_clk;
    if (baud_pulse) send_clk = (baud_cnt == 0);
    else            send_clk = (baud_cnt < baud_period / 2);
    tick_next = send_clk && !sc_prev;
  end

  // Sender model for u0: goes busy dly_cfg cycles after seeing tx_en, stays
  // busy busy_cfg cycles. Ignores the arbiter's reset, like the real sender.
  int         s_ph = 0;
  int         s_cnt = 0;
  int         dly_cfg = 3;
  int         busy_cfg = 20;
  bit         never_busy = 1'b0;
  logic [7:0] sent_q [$];
  always @(posedge clk) begin
    case (s_ph)
      0: if (tx_en && !never_busy) begin
           sent_q.push_back(tx_data);
           s_ph  <= 1;
           s_cnt <= dly_cfg;
         end
      1: if (s_cnt <= 1) begin
           tx_status <= 1'b0;
           s_ph      <= 2;
           s_cnt     <= busy_cfg;
         end else s_cnt <= s_cnt - 1;
      default: if (s_cnt <= 1) begin
           tx_status <= 1'b1;
           s_ph      <= 0;
         end else s_cnt <= s_cnt - 1;
    endcase
  end

  // Sender model for u1: busy one cycle after tx_en, for 6 cycles.
  int s1_ph = 0;
  int s1_cnt = 0;
  always @(posedge clk) begin
    case (s1_ph)
      0: if (tx_en1) s1_ph <= 1;
      1: begin
           tx_status1 <= 1'b0;
           s1_ph      <= 2;
           s1_cnt     <= 6;
         end
      default: if (s1_cnt <= 1) begin
           tx_status1 <= 1'b1;
           s1_ph      <= 0;
         end else s1_cnt <= s1_cnt - 1;
    endcase
  end

  // Reference round-robin rule: first active index after 'last', modulo 4.
  function automatic int rr_pick(input int last, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (m[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && busy1 === 1'b0 && s_ph == 0 && s1_ph == 0 &&
          tx_status === 1'b1 && tx_status1 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++; if (ack !== 4'b0) begin failures++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL reset_grant_id: got %0d want 3", grant_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (grant_id1 !== 2'd3 || busy1 !== 1'b0 || tx_en1 !== 1'b0) begin
      failures++; $display("FAIL reset_zero_gap_inst: got grant=%0d busy=%b tx_en=%b want 3/0/0", grant_id1, busy1, tx_en1);
    end
  endtask

  task automatic test_single();
    bit got, ok;
    int ticks, bad;
    bit last_tick;
    pulse_reset();
    dly_cfg = 3; busy_cfg = 100;
    req_data = 32'h0000_00A5;
    req = 4'b0001;
    wait_ack(50, got);
    checks++; if (!got) begin failures++; $display("FAIL single_ack_seen: got none want ack"); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL single_ack: got %b want 0001", ack); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_grant: got %0d want 0", grant_id); end
    checks++; if (tx_en !== 1'b1) begin failures++; $display("FAIL single_tx_en: got %b want 1", tx_en); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (ack !== 4'b0) begin failures++; $display("FAIL single_ack_width: got %b want 0000", ack); end
    for (int i = 0; i < 50 && tx_status !== 1'b0; i++) @(negedge clk);
    checks++; if (tx_en !== 1'b1) begin failures++; $display("FAIL single_tx_en_hold: got %b want 1", tx_en); end
    @(negedge clk);
    checks++; if (tx_en !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_tx_en_fall: got tx_en=%b busy=%b want 0/1", tx_en, busy);
    end
    bad = 0;
    for (int i = 0; i < 300 && tx_status !== 1'b1; i++) begin
      if (tx_data !== 8'hA5 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL single_frame_hold: got %0d bad cycles want 0", bad); end
    @(negedge clk);
    ticks = 0; last_tick = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy === 1'b0) break;
      if (tick_next) ticks++;
      last_tick = tick_next;
      @(negedge clk);
    end
    checks++; if (ticks != GAP || !last_tick) begin
      failures++; $display("FAIL single_gap_ticks: got %0d (last_tick=%b) want %0d (1)", ticks, last_tick, GAP);
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err: got %b want 0", err); end
    drain(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_drain: got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    bit got, ok;
    int start;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_reset();
    dly_cfg = 2; busy_cfg = 15;
    start = sent_q.size();
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(400, got);
      checks++; if (!got || ack !== 4'(1 << order[n]) || tx_data !== bytes[order[n]] || grant_id !== 2'(order[n])) begin
        failures++; $display("FAIL rr_grant%0d: got ack=%b data=%h id=%0d want ack=%b data=%h id=%0d",
                             n, ack, tx_data, grant_id, 4'(1 << order[n]), bytes[order[n]], order[n]);
      end
      if (n == 4) req = 4'b0000;
      @(negedge clk);
      checks++; if (ack !== 4'b0) begin failures++; $display("FAIL rr_ack_width%0d: got %b want 0000", n, ack); end
    end
    drain(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_drain: got busy=%b want 0", busy); end
    for (int n = 0; n < 5; n++) begin
      checks++; if (sent_q.size() <= start + n || sent_q[start + n] !== bytes[order[n]]) begin
        failures++; $display("FAIL rr_sent%0d: got %h want %h", n,
                             (sent_q.size() > start + n) ? sent_q[start + n] : 8'hxx, bytes[order[n]]);
      end
    end
  endtask

  task automatic test_rotation();
    bit got, ok;
    logic [7:0] b0, b2;
    pulse_reset();
    dly_cfg = 2; busy_cfg = 10;
    b2 = 8'($urandom);
    req_data = {8'h00, b2, 16'h0000};
    req = 4'b0100;
    wait_ack(50, got);
    checks++; if (!got || grant_id !== 2'd2) begin failures++; $display("FAIL rot_first: got id=%0d want 2", grant_id); end
    req = 4'b0000;
    drain(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rot_drain: got busy=%b want 0", busy); end
    b0 = 8'($urandom);
    b2 = 8'($urandom);
    req_data = {8'h00, b2, 8'h00, b0};
    req = 4'b0101;
    wait_ack(50, got);
    checks++; if (!got || ack !== 4'b0001 || tx_data !== b0) begin
      failures++; $display("FAIL rot_wrap: got ack=%b data=%h want 0001/%h", ack, tx_data, b0);
    end
    wait_ack(400, got);
    checks++; if (!got || ack !== 4'b0100 || tx_data !== b2) begin
      failures++; $display("FAIL rot_next: got ack=%b data=%h want 0100/%h", ack, tx_data, b2);
    end
    req = 4'b0000;
    drain(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rot_drain2: got busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    bit got, ok;
    int last, exp_id, start;
    logic [3:0] mask;
    logic [7:0] bytes [4];
    logic [7:0] exp_q [$];
    pulse_reset();
    baud_pulse = 1'b1; baud_period = 4;
    start = sent_q.size();
    last = 3;
    mask = 4'($urandom_range(1, 15));
    for (int j = 0; j < 4; j++) bytes[j] = 8'($urandom);
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    req = mask;
    for (int r = 0; r < 20; r++) begin
      dly_cfg  = $urandom_range(1, 4);
      busy_cfg = $urandom_range(4, 25);
      exp_id = rr_pick(last, mask);
      wait_ack(600, got);
      checks++; if (!got || ack !== 4'(1 << exp_id) || tx_data !== bytes[exp_id] || grant_id !== 2'(exp_id)) begin
        failures++; $display("FAIL rand_grant%0d: got ack=%b data=%h id=%0d want ack=%b data=%h id=%0d",
                             r, ack, tx_data, grant_id, 4'(1 << exp_id), bytes[exp_id], exp_id);
      end
      exp_q.push_back(bytes[exp_id]);
      last = exp_id;
      // Requester either re-requests with a new byte or drops; others may join.
      if ($urandom_range(0, 1) == 1) bytes[exp_id] = 8'($urandom);
      else mask[exp_id] = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (!mask[j] && $urandom_range(0, 3) == 0) begin
          mask[j]  = 1'b1;
          bytes[j] = 8'($urandom);
        end
      end
      if (mask == 4'b0) mask[$urandom_range(0, 3)] = 1'b1;
      if (r == 19) mask = 4'b0;
      req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
      req = mask;
    end
    drain(600, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rand_drain: got busy=%b want 0", busy); end
    foreach (exp_q[k]) begin
      checks++; if (sent_q.size() <= start + k || sent_q[start + k] !== exp_q[k]) begin
        failures++; $display("FAIL rand_sent%0d: got %h want %h", k,
                             (sent_q.size() > start + k) ? sent_q[start + k] : 8'hxx, exp_q[k]);
      end
    end
    baud_pulse = 1'b0; baud_period = 6;
  endtask

  task automatic test_timeout();
    bit got, ok, last_tick;
    int ticks;
    logic [7:0] b;
    pulse_reset();
    never_busy = 1'b1;
    req_data = 32'h0077_0000;
    req = 4'b0100;
    wait_ack(50, got);
    checks++; if (!got || ack !== 4'b0100) begin failures++; $display("FAIL tmo_ack: got %b want 0100", ack); end
    req = 4'b0000;
    ticks = 0; last_tick = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (err === 1'b1 || tx_en === 1'b0) break;
      if (tick_next) ticks++;
      last_tick = tick_next;
      @(negedge clk);
    end
    checks++; if (ticks != TMO || !last_tick) begin
      failures++; $display("FAIL tmo_ticks: got %0d (last_tick=%b) want %0d (1)", ticks, last_tick, TMO);
    end
    checks++; if (err !== 1'b1 || tx_en !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL tmo_flags: got err=%b tx_en=%b busy=%b want 1/0/1", err, tx_en, busy);
    end
    never_busy = 1'b0;
    dly_cfg = 2; busy_cfg = 8;
    b = 8'($urandom);
    req_data = {24'h0, b};
    req = 4'b0001;
    wait_ack(400, got);
    checks++; if (!got || ack !== 4'b0001 || tx_data !== b || err !== 1'b1) begin
      failures++; $display("FAIL tmo_next: got ack=%b data=%h err=%b want 0001/%h/1", ack, tx_data, err, b);
    end
    req = 4'b0000;
    drain(500, ok);
    checks++; if (!ok || err !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got ok=%b err=%b want 1/1", ok, err); end
  endtask

  task automatic test_reset_mid();
    bit got, ok;
    logic prev_ts;
    logic [7:0] b;
    dly_cfg = 2; busy_cfg = 70;
    b = 8'($urandom);
    req_data = {16'h0, b, 8'h00};
    req = 4'b0010;
    wait_ack(400, got);
    checks++; if (!got || ack !== 4'b0010) begin failures++; $display("FAIL rmid_ack: got %b want 0010", ack); end
    for (int i = 0; i < 50 && !(tx_status === 1'b0 && tx_en === 1'b0); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ack !== 4'b0 || tx_en !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd3 || busy !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL rmid_outputs: got ack=%b tx_en=%b data=%h id=%0d busy=%b err=%b want 0000/0/00/3/0/0",
                           ack, tx_en, tx_data, grant_id, busy, err);
    end
    prev_ts = tx_status;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack !== 4'b0) begin
        got = 1'b1;
        break;
      end
      prev_ts = tx_status;
    end
    checks++; if (!got || ack !== 4'b0010 || tx_data !== b) begin
      failures++; $display("FAIL rmid_regrant: got ack=%b data=%h want 0010/%h", ack, tx_data, b);
    end
    checks++; if (prev_ts !== 1'b1) begin failures++; $display("FAIL rmid_busy_block: got tx_status=%b at grant want 1", prev_ts); end
    req = 4'b0000;
    drain(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_drain: got busy=%b want 0", busy); end
  endtask

  task automatic test_zero_gap();
    bit got, ok;
    logic [7:0] b;
    b = 8'($urandom);
    req_data1 = {24'h0, b};
    req1 = 4'b0001;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack1 !== 4'b0) begin got = 1'b1; break; end
    end
    checks++; if (!got || ack1 !== 4'b0001 || tx_data1 !== b) begin
      failures++; $display("FAIL zgap_ack: got ack=%b data=%h want 0001/%h", ack1, tx_data1, b);
    end
    for (int i = 0; i < 50 && tx_status1 !== 1'b0; i++) @(negedge clk);
    for (int i = 0; i < 50 && tx_status1 !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL zgap_in_gap: got busy=%b want 1", busy1); end
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL zgap_idle: got busy=%b want 0", busy1); end
    @(negedge clk);
    checks++; if (ack1 !== 4'b0001) begin failures++; $display("FAIL zgap_next_ack: got %b want 0001", ack1); end
    req1 = 4'b0000;
    drain(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zgap_drain: got busy=%b want 0", busy1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rotation();
    test_random();
    test_timeout();
    test_reset_mid();
    test_zero_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
